// File: rtl/ball_engine.sv
// Pong ball engine: moves the ball on each motion tick, bounces it off walls and paddles,
// detects misses, keeps both scores and holds the game in SERVE/PLAY/OVER.
module ball_engine #(
  parameter int SCREEN_W   = 640,
  parameter int FIELD_TOP  = 10,
  parameter int FIELD_BOT  = 470,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_X0  = 20,
  parameter int PADDLE_X1  = 612,
  parameter int SPEED      = 2,
  parameter int TICK_DIV   = 416667,
  parameter int SERVE_WAIT = 60,
  parameter int WIN_SCORE  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [8:0] paddle_0,
  input  logic [8:0] paddle_1,
  input  logic [5:0] paddlewidth,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic       game_over,
  output logic       point_pulse
);
  // state | meaning
  // SERVE | ball held at centre, counting SERVE_WAIT ticks
  // PLAY  | ball moving, bounces and misses evaluated per tick
  // OVER  | a player reached WIN_SCORE, ticks ignored until restart
  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SWW = $clog2(SERVE_WAIT + 1);
  localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SWW-1:0] SERVE_LAST = SWW'(SERVE_WAIT - 1);

  localparam logic [10:0] L_TOP_S = 11'(FIELD_TOP + SPEED);
  localparam logic [10:0] L_BOT_S = 11'(FIELD_BOT - SPEED);
  localparam logic [10:0] L_B     = 11'(BALL_SIZE);
  localparam logic [10:0] L_S     = 11'(SPEED);
  localparam logic [10:0] L_X0    = 11'(PADDLE_X0);
  localparam logic [10:0] L_X0_S  = 11'(PADDLE_X0 + SPEED);
  localparam logic [10:0] L_X1    = 11'(PADDLE_X1);
  localparam logic [10:0] L_X1_S  = 11'(PADDLE_X1 - SPEED);
  localparam logic [10:0] L_W_S   = 11'(SCREEN_W - SPEED);

  localparam logic [9:0] X_C   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0] Y_C   = 9'((FIELD_TOP + FIELD_BOT - BALL_SIZE) / 2);
  localparam logic [8:0] Y_TOP = 9'(FIELD_TOP);
  localparam logic [8:0] Y_BOT = 9'(FIELD_BOT - BALL_SIZE);
  localparam logic [9:0] X_L   = 10'(PADDLE_X0);
  localparam logic [9:0] X_R   = 10'(PADDLE_X1 - BALL_SIZE);
  localparam logic [8:0] SP9   = 9'(SPEED);
  localparam logic [9:0] SP10  = 10'(SPEED);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  state_t         state, state_nxt;
  logic [TW-1:0]  tick_cnt;
  logic [SWW-1:0] serve_cnt, serve_nxt;
  logic           dir_x, dir_y, dx_nxt, dy_nxt;
  logic [9:0]     x_nxt;
  logic [8:0]     y_nxt;
  logic [3:0]     n0_nxt, n1_nxt;
  logic           pulse_nxt, miss_l, miss_r, tick;
  logic [10:0]    bx, by, p0x, p1x, pwx;
  logic           ov0, ov1;

  assign tick = (tick_cnt == TICK_LAST);
  assign bx   = {1'b0, ball_x};
  assign by   = {2'b00, ball_y};
  assign p0x  = {2'b00, paddle_0};
  assign p1x  = {2'b00, paddle_1};
  assign pwx  = {5'b00000, paddlewidth};
  // Overlap uses the ball row before this tick's vertical move
  assign ov0  = (by + L_B > p0x) && (by < p0x + pwx);
  assign ov1  = (by + L_B > p1x) && (by < p1x + pwx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SERVE;
      tick_cnt    <= '0;
      serve_cnt   <= '0;
      ball_x      <= X_C;
      ball_y      <= Y_C;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      num_0       <= 4'd0;
      num_1       <= 4'd0;
      game_over   <= 1'b0;
      point_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      serve_cnt   <= serve_nxt;
      ball_x      <= x_nxt;
      ball_y      <= y_nxt;
      dir_x       <= dx_nxt;
      dir_y       <= dy_nxt;
      num_0       <= n0_nxt;
      num_1       <= n1_nxt;
      game_over   <= (state_nxt == OVER);
      point_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    serve_nxt = serve_cnt;
    x_nxt     = ball_x;
    y_nxt     = ball_y;
    dx_nxt    = dir_x;
    dy_nxt    = dir_y;
    n0_nxt    = num_0;
    n1_nxt    = num_1;
    pulse_nxt = 1'b0;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
    if (restart) begin
      n0_nxt    = 4'd0;
      n1_nxt    = 4'd0;
      x_nxt     = X_C;
      y_nxt     = Y_C;
      serve_nxt = '0;
      dx_nxt    = 1'b1;
      state_nxt = SERVE;
    end else if (tick) begin
      case (state)
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            serve_nxt = '0;
            state_nxt = PLAY;
          end else begin
            serve_nxt = serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          if (!dir_y && by < L_TOP_S) begin
            y_nxt  = Y_TOP;
            dy_nxt = 1'b1;
          end else if (dir_y && by + L_B > L_BOT_S) begin
            y_nxt  = Y_BOT;
            dy_nxt = 1'b0;
          end else if (dir_y) begin
            y_nxt = ball_y + SP9;
          end else begin
            y_nxt = ball_y - SP9;
          end

          if (!dir_x) begin
            if (bx >= L_X0 && bx < L_X0_S && ov0) begin
              x_nxt  = X_L;
              dx_nxt = 1'b1;
            end else if (bx < L_S) begin
              miss_l = 1'b1;
            end else begin
              x_nxt = ball_x - SP10;
            end
          end else begin
            if (bx + L_B > L_X1_S && bx + L_B <= L_X1 && ov1) begin
              x_nxt  = X_R;
              dx_nxt = 1'b0;
            end else if (bx + L_B > L_W_S) begin
              miss_r = 1'b1;
            end else begin
              x_nxt = ball_x + SP10;
            end
          end

          // Next serve heads toward whoever lost the point
          if (miss_l) begin
            n1_nxt = num_1 + 4'd1;
            dx_nxt = 1'b0;
          end
          if (miss_r) begin
            n0_nxt = num_0 + 4'd1;
            dx_nxt = 1'b1;
          end
          if (miss_l || miss_r) begin
            x_nxt     = X_C;
            y_nxt     = Y_C;
            dy_nxt    = ~dir_y;
            pulse_nxt = 1'b1;
            state_nxt = (n0_nxt == WIN || n1_nxt == WIN) ? OVER : SERVE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: game-rule reference model compared every clock, plus directed
// scenarios for serve timing, paddle bounce, misses, game over, restart and reset.
module tb_ball_engine;
  localparam int W = 640, TOP = 10, BOT = 470, B = 8, X0 = 20, X1 = 612, S = 2;
  localparam int SW = 2, WIN = 9, OFF = 480;
  localparam int XC = (W - B) / 2, YC = (TOP + BOT - B) / 2;

  logic clk = 1'b0;
  logic reset, restart;
  logic [8:0] paddle_0, paddle_1;
  logic [5:0] paddlewidth;
  logic [9:0] ball_x, ball_x2;
  logic [8:0] ball_y, ball_y2;
  logic [3:0] num_0, num_1, num_02, num_12;
  logic game_over, point_pulse, game_over2, point_pulse2;

  int n_cmp = 0, n_fail = 0;
  int mx, my, mdx, mdy, mn0, mn1, mserve, mphase;  // mphase: 0 serve, 1 play, 2 over
  bit mpulse;

  ball_engine #(.TICK_DIV(1), .SERVE_WAIT(SW)) dut (
    .clk(clk), .reset(reset), .restart(restart), .paddle_0(paddle_0), .paddle_1(paddle_1),
    .paddlewidth(paddlewidth), .ball_x(ball_x), .ball_y(ball_y), .num_0(num_0), .num_1(num_1),
    .game_over(game_over), .point_pulse(point_pulse));

  ball_engine #(.TICK_DIV(3), .SERVE_WAIT(SW)) dut_slow (
    .clk(clk), .reset(reset), .restart(restart), .paddle_0(paddle_0), .paddle_1(paddle_1),
    .paddlewidth(paddlewidth), .ball_x(ball_x2), .ball_y(ball_y2), .num_0(num_02), .num_1(num_12),
    .game_over(game_over2), .point_pulse(point_pulse2));

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = XC; my = YC; mdx = 1; mdy = 1; mn0 = 0; mn1 = 0; mserve = 0; mphase = 0; mpulse = 0;
  endtask

  task automatic model_step(input bit r, input int p0, input int p1, input int pw);
    int ny, ndy, nx, ndx;
    bit ov0, ov1, lost_l, lost_r;
    mpulse = 0;
    if (r) begin
      mn0 = 0; mn1 = 0; mx = XC; my = YC; mserve = 0; mdx = 1; mphase = 0;
    end else if (mphase == 0) begin
      if (mserve == SW - 1) begin mserve = 0; mphase = 1; end
      else mserve++;
    end else if (mphase == 1) begin
      ov0 = (my + B > p0) && (my < p0 + pw);
      ov1 = (my + B > p1) && (my < p1 + pw);
      ndy = mdy;
      if (mdy < 0 && my < TOP + S) begin ny = TOP; ndy = 1; end
      else if (mdy > 0 && my + B > BOT - S) begin ny = BOT - B; ndy = -1; end
      else ny = my + mdy * S;
      nx = mx; ndx = mdx; lost_l = 0; lost_r = 0;
      if (mdx < 0) begin
        if (mx >= X0 && mx < X0 + S && ov0) begin nx = X0; ndx = 1; end
        else if (mx < S) lost_l = 1;
        else nx = mx - S;
      end else begin
        if (mx + B > X1 - S && mx + B <= X1 && ov1) begin nx = X1 - B; ndx = -1; end
        else if (mx + B > W - S) lost_r = 1;
        else nx = mx + S;
      end
      if (lost_l || lost_r) begin
        if (lost_l) begin mn1++; ndx = -1; end
        else begin mn0++; ndx = 1; end
        nx = XC; ny = YC; ndy = -mdy; mpulse = 1;
        mphase = (mn0 == WIN || mn1 == WIN) ? 2 : 0;
      end
      mx = nx; my = ny; mdx = ndx; mdy = ndy;
    end
  endtask

  function automatic logic [28:0] dut_vec();
    return {ball_x, ball_y, num_0, num_1, game_over, point_pulse};
  endfunction

  function automatic logic [28:0] mdl_vec();
    return {10'(mx), 9'(my), 4'(mn0), 4'(mn1), mphase == 2, mpulse};
  endfunction

  function automatic string dut_s();
    return $sformatf("x=%0d y=%0d n=%0d/%0d go=%0b pp=%0b", ball_x, ball_y, num_0, num_1,
                     game_over, point_pulse);
  endfunction

  function automatic string mdl_s();
    return $sformatf("x=%0d y=%0d n=%0d/%0d go=%0b pp=%0b", mx, my, mn0, mn1, mphase == 2, mpulse);
  endfunction

  // Paddle placed so its span always covers the ball's current row
  function automatic int track(input int pw);
    int t;
    t = my + 4 - int'($urandom_range(0, pw));
    if (t < 0) t = 0;
    return t;
  endfunction

  task automatic cycle(input bit r, input int p0, input int p1, input int pw);
    @(negedge clk);
    restart = r;
    paddle_0 = p0[8:0];
    paddle_1 = p1[8:0];
    paddlewidth = pw[5:0];
    @(posedge clk);
    #1;
    model_step(r, p0, p1, pw);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; paddle_0 = 9'(OFF); paddle_1 = 9'(OFF); paddlewidth = 6'd40;
    #12;
    model_reset();
    n_cmp++;
    if (dut_vec() !== {10'd316, 9'd236, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: got %s, need x=316 y=236 n=0/0 go=0 pp=0", dut_s());
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_serve();
    for (int i = 1; i <= 3; i++) begin
      cycle(0, OFF, OFF, 40);
      n_cmp++;
      if (ball_x !== 10'((i < 3) ? 316 : 318) || ball_y !== 9'((i < 3) ? 236 : 238)) begin
        n_fail++; $display("FAIL serve_tick%0d: got %s", i, dut_s());
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL serve_model: dut %s, model %s", dut_s(), mdl_s());
      end
    end
  endtask

  task automatic test_right_miss();
    bit seen = 0, passed_paddle = 0, bottom_hold = 0;
    int prev_x = ball_x, prev_y = ball_y;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle(0, OFF, OFF, 40);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL right_miss_model: dut %s, model %s", dut_s(), mdl_s());
      end
      if (prev_x == 604 && ball_x == 10'd606) passed_paddle = 1;
      if (prev_y == 462 && ball_y == 9'd462) bottom_hold = 1;
      prev_x = ball_x; prev_y = ball_y;
      seen = point_pulse;
    end
    n_cmp++;
    if (!seen || num_0 !== 4'd1 || num_1 !== 4'd0 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_fail++; $display("FAIL right_miss_score: seen=%0b got %s, need n=1/0 centred", seen, dut_s());
    end
    n_cmp++;
    if (!passed_paddle || !bottom_hold) begin
      n_fail++; $display("FAIL right_miss_path: passed_paddle=%0b bottom_hold=%0b, need 1/1",
                         passed_paddle, bottom_hold);
    end
    cycle(0, OFF, OFF, 40);
    n_cmp++;
    if (point_pulse !== 1'b0) begin
      n_fail++; $display("FAIL point_pulse_width: got %0b, need 0", point_pulse);
    end
  endtask

  task automatic test_paddle_bounce();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(0, OFF, track(63), 63);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL bounce_model: dut %s, model %s", dut_s(), mdl_s());
      end
      found = (ball_x == 10'd604);
    end
    cycle(0, OFF, track(63), 63);
    n_cmp++;
    if (!found || ball_x !== 10'd604) begin
      n_fail++; $display("FAIL bounce_face: found=%0b got x=%0d, need 604", found, ball_x);
    end
    cycle(0, OFF, track(63), 63);
    n_cmp++;
    if (ball_x !== 10'd602) begin
      n_fail++; $display("FAIL bounce_reverse: got x=%0d, need 602", ball_x);
    end
  endtask

  task automatic test_left_win();
    logic [28:0] frozen;
    for (int i = 0; i < 5000 && !game_over; i++) begin
      cycle(0, OFF, track(63), 63);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL left_win_model: dut %s, model %s", dut_s(), mdl_s());
      end
    end
    n_cmp++;
    if (dut_vec() !== {10'd316, 9'd236, 4'd1, 4'd9, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL game_over_entry: got %s, need x=316 y=236 n=1/9 go=1 pp=1", dut_s());
    end
    frozen = {10'd316, 9'd236, 4'd1, 4'd9, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cycle(0, track(63), track(63), 63);
      n_cmp++;
      if (dut_vec() !== frozen) begin
        n_fail++; $display("FAIL over_frozen: got %s, need x=316 y=236 n=1/9 go=1 pp=0", dut_s());
      end
    end
  endtask

  task automatic test_restart_over();
    cycle(1, OFF, OFF, 40);
    n_cmp++;
    if (dut_vec() !== {10'd316, 9'd236, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL restart_over: got %s, need x=316 y=236 n=0/0 go=0", dut_s());
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(0, OFF, OFF, 40);
      n_cmp++;
      if (ball_x !== 10'((i < 3) ? 316 : 318)) begin
        n_fail++; $display("FAIL restart_serve%0d: got x=%0d", i, ball_x);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL restart_model: dut %s, model %s", dut_s(), mdl_s());
      end
    end
  endtask

  task automatic test_restart_vs_miss();
    bit armed = 0;
    for (int i = 0; i < 1000 && !armed; i++) begin
      armed = (mphase == 1) && ((mdx > 0 && mx + B > W - S) || (mdx < 0 && mx < S));
      if (!armed) cycle(0, OFF, OFF, 40);
    end
    cycle(1, OFF, OFF, 40);
    n_cmp++;
    if (!armed || dut_vec() !== {10'd316, 9'd236, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL restart_priority: armed=%0b got %s, need n=0/0 pp=0", armed, dut_s());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) cycle(0, OFF, OFF, 40);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== {10'd316, 9'd236, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got %s, need reset values", dut_s());
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_tick_div();
    for (int e = 1; e <= 12; e++) begin
      cycle(0, OFF, OFF, 40);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL tick_div_fast_model: dut %s, model %s", dut_s(), mdl_s());
      end
      if (e == 8 || e == 9 || e == 11 || e == 12) begin
        n_cmp++;
        if (ball_x2 !== 10'((e == 8) ? 316 : (e == 12) ? 320 : 318)) begin
          n_fail++; $display("FAIL tick_div_edge%0d: got x=%0d", e, ball_x2);
        end
      end
    end
  endtask

  task automatic test_random();
    int pw = 40, p0, p1;
    bit r;
    for (int i = 0; i < 15000; i++) begin
      if (i % 100 == 0) pw = $urandom_range(8, 63);
      p0 = ($urandom_range(0, 9) < 7) ? track(pw) : int'($urandom_range(0, 480));
      p1 = ($urandom_range(0, 9) < 7) ? track(pw) : int'($urandom_range(0, 480));
      r = ($urandom_range(0, 3999) == 0);
      cycle(r, p0, p1, pw);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_model cyc%0d: dut %s, model %s", i, dut_s(), mdl_s());
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_right_miss();
    test_paddle_bounce();
    test_left_win();
    test_restart_over();
    test_restart_vs_miss();
    test_async_reset();
    test_tick_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Game-logic stage between the paddle position counters and the video renderer.
- Moves the ball each frame tick and bounces it off the top/bottom walls and both paddles.
- Detects misses, keeps both scores, and drives num_0/num_1 back to the paddle counters, which reset when a score exceeds 8.
- Outputs ball coordinates and game state to the pixel generator.

Parameters:
- SCREEN_W, 640: visible width in pixels.
- FIELD_TOP, 10: top wall y; matches the paddle minimum.
- FIELD_BOT, 470: bottom wall y; matches the paddle maximum.
- BALL_SIZE, 8: ball side length in pixels.
- PADDLE_X0, 20: x of the left paddle's right face.
- PADDLE_X1, 612: x of the right paddle's left face.
- SPEED, 2: pixels moved per tick on each axis.
- TICK_DIV, 416667: clocks per motion tick (120 Hz at 50 MHz).
- SERVE_WAIT, 60: ticks the ball is held before each serve.
- WIN_SCORE, 9: score that ends the game.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- restart, input, 1: single-cycle pulse, already debounced and edge-detected upstream; starts a new game.
- paddle_0, input, 9: left paddle top y.
- paddle_1, input, 9: right paddle top y.
- paddlewidth, input, 6: paddle height in pixels.
- ball_x, output, 10: ball left x.
- ball_y, output, 9: ball top y.
- num_0, output, 4: left player score.
- num_1, output, 4: right player score.
- game_over, output, 1: high in the OVER state.
- point_pulse, output, 1: one-cycle strobe on each score increment.

Behaviour:
- Reset (asynchronous):
  - state=SERVE; tick counter=0; serve counter=0.
  - ball_x=(SCREEN_W-BALL_SIZE)/2=316; ball_y=(FIELD_TOP+FIELD_BOT-BALL_SIZE)/2=236.
  - dir_x=right; dir_y=down.
  - num_0=num_1=0; game_over=0; point_pulse=0.
- Tick:
  - Free-running counter 0..TICK_DIV-1; tick=1 on the cycle where counter==TICK_DIV-1.
  - All ball, state and score updates happen only on tick cycles.
  - Paddle inputs are sampled on the tick cycle.
- SERVE:
  - Ball held at centre.
  - Serve counter increments per tick; at SERVE_WAIT-1 it clears and state goes to PLAY.
  - Ball first moves on the next tick.
- PLAY, vertical axis (per tick):
  - Moving up and ball_y < FIELD_TOP+SPEED: ball_y=FIELD_TOP, dir_y=down.
  - Moving down and ball_y+BALL_SIZE > FIELD_BOT-SPEED: ball_y=FIELD_BOT-BALL_SIZE, dir_y=up.
  - Otherwise: ball_y ±= SPEED.
- PLAY, horizontal axis (same tick, evaluated independently of the vertical axis):
  - Overlap definition, using pre-update ball_y: ball_y+BALL_SIZE > paddle_k AND ball_y < paddle_k+paddlewidth.
  - Left, moving left, ball_x < PADDLE_X0+SPEED, ball_x >= PADDLE_X0:
    - Overlap with paddle_0: ball_x=PADDLE_X0, dir_x=right.
    - No overlap: continue moving.
  - Left, moving left, ball_x < SPEED: miss; num_1++.
  - Right, moving right, ball_x+BALL_SIZE > PADDLE_X1-SPEED, ball_x+BALL_SIZE <= PADDLE_X1:
    - Overlap with paddle_1: ball_x=PADDLE_X1-BALL_SIZE, dir_x=left.
    - No overlap: continue moving.
  - Right, moving right, ball_x+BALL_SIZE > SCREEN_W-SPEED: miss; num_0++.
  - Otherwise: ball_x ±= SPEED.
- Miss:
  - Score increments; point_pulse=1 for exactly that clock.
  - Ball re-centred; dir_x points toward the player who lost the point; dir_y toggles.
  - If the new score == WIN_SCORE: state=OVER; else state=SERVE.
- OVER:
  - game_over=1; ball held at centre; scores frozen (num=9 forces the paddle counters to reset).
  - Ticks are ignored.
- restart pulse, any state, any cycle:
  - num_0=num_1=0; ball centred; serve counter=0; dir_x=right; state=SERVE; game_over=0.
  - restart has priority over a same-cycle miss.
- Arithmetic: all comparisons unsigned, computed at 11 bits to avoid wrap. Scores never exceed WIN_SCORE.
- Outputs are registered.

Test Plan (TICK_DIV=1, SERVE_WAIT=2, SPEED=2):
- Reset release -> ball (316,236), num 0/0, state SERVE for 2 ticks, then ball_x=318 and ball_y=238 on the 3rd tick.
- Ball moving up at ball_y=11 -> next tick ball_y=10, dir_y=down; following tick ball_y=12.
- Ball moving right at ball_x=603, paddle_1=200, paddlewidth=40, ball_y=210 -> ball_x=604, dir_x=left.
- Same case but paddle_1=300 -> ball continues; when ball_x+8 > 638, num_0 goes 0->1, point_pulse is high for 1 clock, ball re-centred, dir_x=right.
- num_1=8 and left miss -> num_1=9, game_over=1; further ticks leave ball and scores unchanged.
- restart in OVER -> next clock num 0/0, game_over=0, state SERVE.
- reset asserted mid-PLAY -> outputs return to reset values immediately, with no clock edge.
